// File: rtl/ahb_decoder_resp_mux_if.sv
// Bus bundle between an AHB master/slave fabric and the decoder/response mux.
// The slave modport is the decoder's view; the master modport drives the requests and slave responses.
interface ahb_decoder_resp_mux_if #(
  parameter int NO_OF_SLAVES = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32
);
  logic [ADDR_WIDTH-1:0]              HADDR;
  logic [1:0]                         HTRANS;
  logic [NO_OF_SLAVES-1:0]            HSEL;
  logic                               HSEL_DEFAULT;
  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] hrdata_s;
  logic [NO_OF_SLAVES-1:0]            hready_s;
  logic [2*NO_OF_SLAVES-1:0]          hresp_s;
  logic [DATA_WIDTH-1:0]              hrdata_default;
  logic                               hready_default;
  logic [1:0]                         hresp_default;
  logic [DATA_WIDTH-1:0]              HRDATA;
  logic                               HREADY;
  logic [1:0]                         HRESP;
  logic                               timeout_err;

  modport slave (
    input  HADDR, HTRANS, hrdata_s, hready_s, hresp_s,
           hrdata_default, hready_default, hresp_default,
    output HSEL, HSEL_DEFAULT, HRDATA, HREADY, HRESP, timeout_err
  );

  modport master (
    output HADDR, HTRANS, hrdata_s, hready_s, hresp_s,
           hrdata_default, hready_default, hresp_default,
    input  HSEL, HSEL_DEFAULT, HRDATA, HREADY, HRESP, timeout_err
  );
endinterface

// File: rtl/ahb_decoder_resp_mux.sv
// AHB address decoder plus data-phase response mux, with a watchdog that ends
// over-long slave stalls with a two-cycle ERROR response.
module ahb_decoder_resp_mux #(
  parameter int NO_OF_SLAVES   = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NO_OF_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NO_OF_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic HCLK,
  input logic HRESET,
  ahb_decoder_resp_mux_if.slave bus
);
  localparam int NS = NO_OF_SLAVES;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10, SEQ = 2'b11;

  typedef enum logic [1:0] {NORMAL, ERR1, ERR2} state_e;

  state_e         state_q, state_d;
  logic [NS:0]    dsel_q, dsel_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
  logic           terr_q, terr_d;

  logic [NS-1:0]  hsel;
  logic           hit;
  logic [DW-1:0]  sel_data, hrdata;
  logic           sel_ready, hready, active, stalled;
  logic [1:0]     sel_resp, hresp;

  // Lowest index wins so overlapping windows still give a one-hot select.
  always_comb begin
    hsel = '0;
    hit  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!hit && ((bus.HADDR & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW])) begin
        hsel[i] = 1'b1;
        hit     = 1'b1;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_ready = 1'b1;
    sel_resp  = OKAY;
    for (int i = 0; i < NS; i++) begin
      if (dsel_q[i]) begin
        sel_data  = bus.hrdata_s[i*DW +: DW];
        sel_ready = bus.hready_s[i];
        sel_resp  = bus.hresp_s[2*i +: 2];
      end
    end
    if (dsel_q[NS]) begin
      sel_data  = bus.hrdata_default;
      sel_ready = bus.hready_default;
      sel_resp  = bus.hresp_default;
    end
  end

  assign active  = |dsel_q;
  assign stalled = (state_q == NORMAL) && active && !sel_ready;

  // While the watchdog owns the bus the stalled slave is ignored entirely.
  always_comb begin
    hrdata = '0;
    hready = 1'b1;
    hresp  = OKAY;
    case (state_q)
      NORMAL: begin
        if (active) begin
          hrdata = sel_data;
          hready = sel_ready;
          hresp  = sel_resp;
        end
      end
      ERR1: begin
        hready = 1'b0;
        hresp  = ERROR;
      end
      ERR2: hresp = ERROR;
      default: ;
    endcase
  end

  always_comb begin
    dsel_d     = dsel_q;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    terr_d     = 1'b0;
    if (hready) begin
      dsel_d = ((bus.HTRANS == NONSEQ) || (bus.HTRANS == SEQ)) ? {~hit, hsel} : '0;
    end
    case (state_q)
      NORMAL: begin
        if (stalled) begin
          if (wait_cnt_q == LIMIT) begin
            state_d    = ERR1;
            wait_cnt_d = '0;
            terr_d     = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end else begin
          wait_cnt_d = '0;
        end
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q     <= '0;
      state_q    <= NORMAL;
      wait_cnt_q <= '0;
      terr_q     <= 1'b0;
    end else begin
      dsel_q     <= dsel_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      terr_q     <= terr_d;
    end
  end

  assign bus.HSEL         = hsel;
  assign bus.HSEL_DEFAULT = ~hit;
  assign bus.HRDATA       = hrdata;
  assign bus.HREADY       = hready;
  assign bus.HRESP        = hresp;
  assign bus.timeout_err  = terr_q;
endmodule

// File: tb/tb_ahb_decoder_resp_mux.sv
// Bench for ahb_decoder_resp_mux: table of back-to-back transfers through a
// data-phase scoreboard, then hand-built wait, timeout, boundary and reset sequences.
module tb_ahb_decoder_resp_mux;
  localparam int NS = 4, AW = 32, DW = 32, TO = 16;
  localparam logic [NS*AW-1:0] BASE = {32'h0000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFF00_0000};
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_decoder_resp_mux_if #(.NO_OF_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_decoder_resp_mux #(
    .NO_OF_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [3:0]  hsel;
    logic        hdef;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        ready;
    logic [1:0]  resp;
  } dp_t;

  vec_t vecs[8];
  dp_t  sbq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic dp_check();
    dp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk("sb_hrdata", bus.HRDATA, e.rdata);
      chk("sb_hready", bus.HREADY, e.ready);
      chk("sb_hresp",  bus.HRESP,  e.resp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    bus.HADDR  = a;
    bus.HTRANS = t;
  endtask

  task automatic stall_to_err1(input logic [31:0] a);
    @(negedge HCLK);
    drive(a, NSQ);
    bus.hready_s[0] = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(negedge HCLK);
      drive(32'h0, IDLE);
      #1;
      chk("stall_hready", bus.HREADY, 0);
      chk("stall_terr", bus.timeout_err, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h1000_0040, NSQ,  4'b0010, 1'b0, 32'hA5A5_0001, 2'b00};
    vecs[1] = '{32'hF000_0000, NSQ,  4'b0000, 1'b1, 32'hDEAD_BEEF, 2'b01};
    vecs[2] = '{32'h0000_1234, SQ,   4'b0001, 1'b0, 32'hA5A5_0000, 2'b00};
    vecs[3] = '{32'h0100_0000, NSQ,  4'b1000, 1'b0, 32'hA5A5_0003, 2'b00};
    vecs[4] = '{32'h2000_0008, IDLE, 4'b0100, 1'b0, 32'h0,         2'b00};
    vecs[5] = '{32'h3000_0000, BUSY, 4'b0000, 1'b1, 32'h0,         2'b00};
    vecs[6] = '{32'h2ABC_0000, SQ,   4'b0100, 1'b0, 32'hA5A5_0002, 2'b00};
    vecs[7] = '{32'h1FFF_FFFC, NSQ,  4'b0010, 1'b0, 32'hA5A5_0001, 2'b00};

    for (int i = 0; i < NS; i++) bus.hrdata_s[i*DW +: DW] = 32'(32'hA5A5_0000 + i);
    bus.hready_s       = '1;
    bus.hresp_s        = '0;
    bus.hrdata_default = 32'hDEAD_BEEF;
    bus.hready_default = 1'b1;
    bus.hresp_default  = 2'b01;

    // Reset: data phase stays idle even with a NONSEQ presented
    HRESET = 1'b1;
    drive(32'h1000_0040, NSQ);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hready", bus.HREADY, 1);
    chk("rst_hresp", bus.HRESP, 0);
    chk("rst_hrdata", bus.HRDATA, 0);
    chk("rst_terr", bus.timeout_err, 0);
    chk("rst_hsel", bus.HSEL, 4'b0010);
    drive(32'h0, IDLE);
    HRESET = 1'b0;

    // Back-to-back table through the scoreboard
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      if (i > 0) dp_check();
      drive(vecs[i].addr, vecs[i].trans);
      #1;
      chk("dec_hsel", bus.HSEL, vecs[i].hsel);
      chk("dec_hdef", bus.HSEL_DEFAULT, vecs[i].hdef);
      if (vecs[i].trans[1]) sbq.push_back('{vecs[i].rdata, 1'b1, vecs[i].resp});
      else                  sbq.push_back('{32'h0, 1'b1, 2'b00});
    end
    @(negedge HCLK);
    dp_check();
    drive(32'h0, IDLE);

    // Waited transfer on slave 2, dsel must hold while HADDR moves on
    @(negedge HCLK);
    drive(32'h2000_0010, NSQ);
    bus.hready_s[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      drive(32'h1000_0000, NSQ);
      #1;
      chk("wait_hready", bus.HREADY, 0);
      chk("wait_hrdata", bus.HRDATA, 32'hA5A5_0002);
      chk("wait_hsel", bus.HSEL, 4'b0010);
      chk("wait_terr", bus.timeout_err, 0);
    end
    @(negedge HCLK);
    bus.hready_s[2] = 1'b1;
    #1;
    chk("wait_done_hready", bus.HREADY, 1);
    chk("wait_done_hrdata", bus.HRDATA, 32'hA5A5_0002);
    @(negedge HCLK);
    drive(32'h0, IDLE);
    #1;
    chk("wait_next_hrdata", bus.HRDATA, 32'hA5A5_0001);
    chk("wait_next_terr", bus.timeout_err, 0);

    // Timeout: 16 stalled cycles then ERR1, ERR2; late hready ignored
    stall_to_err1(32'h0000_0004);
    @(negedge HCLK);
    bus.hready_s[0] = 1'b1;
    drive(32'h1000_0000, NSQ);
    #1;
    chk("err1_hready", bus.HREADY, 0);
    chk("err1_hresp", bus.HRESP, 2'b01);
    chk("err1_hrdata", bus.HRDATA, 0);
    chk("err1_terr", bus.timeout_err, 1);
    @(negedge HCLK);
    #1;
    chk("err2_hready", bus.HREADY, 1);
    chk("err2_hresp", bus.HRESP, 2'b01);
    chk("err2_hrdata", bus.HRDATA, 0);
    chk("err2_terr", bus.timeout_err, 0);
    @(negedge HCLK);
    drive(32'h0, IDLE);
    #1;
    chk("post_err_hrdata", bus.HRDATA, 32'hA5A5_0001);
    chk("post_err_hready", bus.HREADY, 1);
    chk("post_err_hresp", bus.HRESP, 0);

    // Boundary: slave ready on the 16th data-phase cycle wins
    @(negedge HCLK);
    drive(32'h0000_0008, NSQ);
    bus.hready_s[0] = 1'b0;
    for (int k = 0; k < TO - 1; k++) begin
      @(negedge HCLK);
      drive(32'h0, IDLE);
      #1;
      chk("bnd_stall_hready", bus.HREADY, 0);
    end
    @(negedge HCLK);
    bus.hready_s[0] = 1'b1;
    #1;
    chk("bnd_hready", bus.HREADY, 1);
    chk("bnd_hresp", bus.HRESP, 0);
    chk("bnd_hrdata", bus.HRDATA, 32'hA5A5_0000);
    @(negedge HCLK);
    #1;
    chk("bnd_after_terr", bus.timeout_err, 0);
    chk("bnd_after_hready", bus.HREADY, 1);
    chk("bnd_after_hresp", bus.HRESP, 0);

    // Reset during ERR1 aborts without ERR2
    stall_to_err1(32'h0000_000C);
    @(negedge HCLK);
    #1;
    chk("rerr1_terr", bus.timeout_err, 1);
    HRESET = 1'b1;
    @(negedge HCLK);
    #1;
    chk("rerr_hready", bus.HREADY, 1);
    chk("rerr_hresp", bus.HRESP, 0);
    chk("rerr_hrdata", bus.HRDATA, 0);
    chk("rerr_terr", bus.timeout_err, 0);
    HRESET = 1'b0;
    bus.hready_s[0] = 1'b1;
    @(negedge HCLK);
    #1;
    chk("rerr_after_hresp", bus.HRESP, 0);
    chk("rerr_after_hready", bus.HREADY, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
